mem_io_unit: RTL and testbench
==============================

# mem_io_unit

Responder side of the memory-stage data interface. Accepts one read or write per request from the memory pipeline stage and decodes page bit `address[16]` to route it: page 0 goes to the 8-bit external data SRAM, page 1 to the 12-bit framebuffer RAM port. It sequences wait states and raises a stall to the pipeline while an access is in flight. SRAM read bytes are returned sign-extended to 12 bits.

## Interface
- `WAIT_STATES`, 2: extra SRAM access cycles; legal range 0..15.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 17: bit 16 is the page (0 = SRAM, 1 = framebuffer); bits [15:0] are the word address.
- `mem_write_data` in 12: store data. The SRAM page uses only [7:0].
- `mem_rd` in 1: read request.
- `mem_wr` in 1: write request.
- `mem_read_data` out 12: registered load result, held until the next read completes.
- `rd_valid` out 1: one-cycle pulse when `mem_read_data` updates.
- `mem_busy` out 1: stall to the pipeline.
- `sram_addr` out 16, `sram_wdata` out 8, `sram_rdata` in 8: SRAM address and data.
- `sram_ce`, `sram_oe`, `sram_we` out 1 each: active-high SRAM strobes.
- `fb_addr` out 16, `fb_wdata` out 12, `fb_rdata` in 12: framebuffer address and data. The port is synchronous with 1-cycle read latency.
- `fb_re`, `fb_we` out 1 each: framebuffer read and write strobes.

## Operation
- FSM states:
  - `IDLE`
  - `SRAM_ACC`
  - `FB_ACC`
  - `FB_WAIT`
  - `DONE`
- Acceptance:
  - A request is accepted in `IDLE` when `mem_rd | mem_wr` is high.
  - On acceptance, `address`, `mem_write_data` and the request type are captured into internal registers.
  - Request inputs are ignored in every state other than `IDLE`.
- Simultaneous `mem_rd` and `mem_wr`: treated as a write. No read is performed and no `rd_valid` is produced.
- Transitions:
  - `IDLE` goes to `SRAM_ACC` if page 0, or to `FB_ACC` if page 1.
  - `SRAM_ACC` stays for WAIT_STATES+1 cycles (4-bit down-counter), then goes to `DONE`.
  - `FB_ACC` lasts 1 cycle, then `FB_WAIT` lasts 1 cycle, then `DONE`.
  - `DONE` lasts 1 cycle, then returns to `IDLE`.
- SRAM cycle:
  - Throughout all of `SRAM_ACC`: `sram_ce` high, `sram_addr` = captured [15:0].
  - Read: `sram_oe` high.
  - Write: `sram_we` high and `sram_wdata` = captured [7:0].
  - Read data: `sram_rdata` is sampled on the edge leaving the last `SRAM_ACC` cycle and stored as {4{d[7]}, d}.
- Framebuffer cycle:
  - In `FB_ACC`: `fb_re` or `fb_we` is high for exactly that cycle, with `fb_addr` and `fb_wdata` driven from the captured values.
  - Read data: `fb_rdata` is stored unmodified on the edge leaving `FB_WAIT`.
- `rd_valid` is high in `DONE` only for reads.
- `mem_busy` = (state ∈ {`SRAM_ACC`, `FB_ACC`, `FB_WAIT`}) | (state == `IDLE` & (`mem_rd` | `mem_wr`)). It is combinational so the pipeline holds in the accept cycle, and it is low in `DONE`, which lets the pipeline advance.
- Strobes are registered outputs and never glitch between states.
- Reset values:
  - state = `IDLE`, counter = 0.
  - `mem_read_data` = 0, `rd_valid` = 0.
  - All strobes = 0, all address and data outputs = 0.
  - `mem_busy` = 0 while `reset` is high, regardless of requests.
- Reset mid-access: the access is aborted, strobes are low after the reset edge, no `rd_valid` is produced, and `mem_read_data` is cleared.
- Address wrap: none. The 16-bit word address is passed through unchanged.

## Timing
- Request accepted in cycle T.
- SRAM access:
  - `SRAM_ACC` occupies T+1..T+1+WAIT_STATES.
  - `DONE` (with `rd_valid` for reads) is at T+2+WAIT_STATES.
  - `mem_busy` is high T..T+1+WAIT_STATES.
  - With the default WAIT_STATES=2, `DONE` is at T+4.
- Framebuffer access:
  - `FB_ACC` at T+1, `FB_WAIT` at T+2, `DONE` at T+3.
  - `mem_busy` is high T..T+2.
- Back-to-back requests: the earliest next acceptance is the cycle after `DONE`.
  - SRAM throughput is one access per WAIT_STATES+3 cycles.
  - Framebuffer throughput is one access per 4 cycles.
- `mem_read_data` is stable from `DONE` until the next read's `DONE`. Writes do not alter it.

## Test plan
- SRAM signed read: WAIT_STATES=2, address=0x00123, `mem_rd` at T, `sram_rdata`=0x9C.
  - `sram_oe`/`sram_ce` high at T+1..T+3.
  - `rd_valid` at T+4 with `mem_read_data`=0xF9C.
  - `mem_busy` high at T..T+3.
- SRAM positive read and write: write address=0x000FF with `mem_write_data`=0xA5B, then read with `sram_rdata`=0x5B.
  - The write cycle shows `sram_wdata`=0x5B and `sram_we` high for 3 cycles.
  - The read returns `mem_read_data`=0x05B.
- Framebuffer read: address=0x1_2000, `mem_rd` at T, `fb_rdata`=0xABC presented at T+2.
  - `fb_re` high only at T+1, `fb_addr`=0x2000.
  - `rd_valid` at T+3 with `mem_read_data`=0xABC.
- Simultaneous `mem_rd`=`mem_wr`=1 to the framebuffer with data 0x123: `fb_we` pulses once with `fb_wdata`=0x123; `fb_re` never asserts and `rd_valid` never asserts.
- Reset mid-access: assert `reset` at T+2 of an SRAM read.
  - Strobes are 0 from T+3 and `mem_read_data`=0.
  - No `rd_valid` appears, and `mem_busy`=0 while `reset` is high.
- Back-to-back: hold `mem_rd` high continuously with WAIT_STATES=0; `rd_valid` pulses every 3 cycles.

Source files
------------

// File: rtl/mem_io_unit_if.sv
// Memory-stage request/response bundle between the pipeline and mem_io_unit.
// The pipeline side drives requests; the unit returns load data and the stall.
interface mem_io_unit_if;
    logic [16:0] address;
    logic [11:0] mem_write_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [11:0] mem_read_data;
    logic        rd_valid;
    logic        mem_busy;

    modport master (
        output address, mem_write_data, mem_rd, mem_wr,
        input  mem_read_data, rd_valid, mem_busy
    );

    modport slave (
        input  address, mem_write_data, mem_rd, mem_wr,
        output mem_read_data, rd_valid, mem_busy
    );
endinterface

// File: rtl/mem_io_unit.sv
// Memory-stage responder: routes one access to the 8-bit SRAM (page 0)
// or the 12-bit framebuffer (page 1), sequencing wait states and stalls.
module mem_io_unit #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic          clock,
    input  logic          reset,
    mem_io_unit_if.slave  mem,
    output logic [15:0]   sram_addr,
    output logic [7:0]    sram_wdata,
    input  logic [7:0]    sram_rdata,
    output logic          sram_ce,
    output logic          sram_oe,
    output logic          sram_we,
    output logic [15:0]   fb_addr,
    output logic [11:0]   fb_wdata,
    input  logic [11:0]   fb_rdata,
    output logic          fb_re,
    output logic          fb_we
);
    typedef enum logic [2:0] {
        IDLE,
        SRAM_ACC,
        FB_ACC,
        FB_WAIT,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [11:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [11:0] rdata_q, rdata_d;
    logic        rdv_q, rdv_d;
    logic        ce_q, ce_d;
    logic        oe_q, oe_d;
    logic        we_q, we_d;
    logic        fre_q, fre_d;
    logic        fwe_q, fwe_d;
    logic        req;

    assign req = mem.mem_rd | mem.mem_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem.address[15:0];
                    wdata_d = mem.mem_write_data;
                    // rd+wr together is a write
                    wr_d    = mem.mem_wr;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = mem.address[16] ? FB_ACC : SRAM_ACC;
                end
            end
            SRAM_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!wr_q) begin
                        rdata_d = {{4{sram_rdata[7]}}, sram_rdata};
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FB_ACC: state_d = FB_WAIT;
            FB_WAIT: begin
                state_d = DONE;
                if (!wr_q) begin
                    rdata_d = fb_rdata;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they are glitch-free registers
        ce_d  = (state_d == SRAM_ACC);
        oe_d  = ce_d & ~wr_d;
        we_d  = ce_d & wr_d;
        fre_d = (state_d == FB_ACC) & ~wr_d;
        fwe_d = (state_d == FB_ACC) & wr_d;
        rdv_d = (state_d == DONE) & ~wr_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'd0;
            wdata_q <= 12'd0;
            wr_q    <= 1'b0;
            rdata_q <= 12'd0;
            rdv_q   <= 1'b0;
            ce_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            fre_q   <= 1'b0;
            fwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
            ce_q    <= ce_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            fre_q   <= fre_d;
            fwe_q   <= fwe_d;
        end
    end

    assign mem.mem_busy = ~reset & (
        (state_q == SRAM_ACC) | (state_q == FB_ACC) |
        (state_q == FB_WAIT)  | ((state_q == IDLE) & req));

    assign mem.mem_read_data = rdata_q;
    assign mem.rd_valid      = rdv_q;

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q[7:0];
    assign sram_ce    = ce_q;
    assign sram_oe    = oe_q;
    assign sram_we    = we_q;
    assign fb_addr    = addr_q;
    assign fb_wdata   = wdata_q;
    assign fb_re      = fre_q;
    assign fb_we      = fwe_q;
endmodule

// File: tb/tb_mem_io_unit.sv
// Randomised self-checking bench for mem_io_unit against a timeline model.
// Instance A uses 2 wait states, instance B uses 0 for back-to-back reads.
module tb_mem_io_unit;
    localparam int WS_A = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_io_unit_if if_a ();
    mem_io_unit_if if_b ();

    logic [15:0] sa_addr, sb_addr, fa_addr, fb_addr_b;
    logic [7:0]  sa_wdata, sb_wdata, sa_rdata, sb_rdata;
    logic [11:0] fa_wdata, fb_wdata_b, fa_rdata, fb_rdata_b;
    logic        sa_ce, sa_oe, sa_we, sb_ce, sb_oe, sb_we;
    logic        fa_re, fa_we, fb_re_b, fb_we_b;

    int checks = 0;
    int failures = 0;
    logic [11:0] exp_rd = 12'd0;

    mem_io_unit #(.WAIT_STATES(WS_A)) dut_a (
        .clock(clock), .reset(reset), .mem(if_a),
        .sram_addr(sa_addr), .sram_wdata(sa_wdata), .sram_rdata(sa_rdata),
        .sram_ce(sa_ce), .sram_oe(sa_oe), .sram_we(sa_we),
        .fb_addr(fa_addr), .fb_wdata(fa_wdata), .fb_rdata(fa_rdata),
        .fb_re(fa_re), .fb_we(fa_we)
    );

    mem_io_unit #(.WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset), .mem(if_b),
        .sram_addr(sb_addr), .sram_wdata(sb_wdata), .sram_rdata(sb_rdata),
        .sram_ce(sb_ce), .sram_oe(sb_oe), .sram_we(sb_we),
        .fb_addr(fb_addr_b), .fb_wdata(fb_wdata_b), .fb_rdata(fb_rdata_b),
        .fb_re(fb_re_b), .fb_we(fb_we_b)
    );

    // One access on instance A, starting in an IDLE cycle; ends in the IDLE after DONE
    task automatic run_access(input bit fb, input logic [15:0] a,
                              input bit rd, input bit wr,
                              input logic [11:0] wd, input logic [7:0] srd,
                              input logic [11:0] frd);
        bit rde;
        int last;
        logic e_ce, e_oe, e_we, e_re, e_fwe, e_rdv, e_busy;
        logic [6:0] exp_v, got_v;
        rde  = rd && !wr;
        last = fb ? 3 : WS_A + 2;
        if_a.address        = {fb, a};
        if_a.mem_write_data = wd;
        if_a.mem_rd         = rd;
        if_a.mem_wr         = wr;
        sa_rdata            = 8'($urandom);
        fa_rdata            = 12'($urandom);
        #1;
        checks++;
        if (if_a.mem_busy !== 1'b1) begin
            failures++;
            $display("FAIL accept_busy got=%b exp=1", if_a.mem_busy);
        end
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clock);
            #1;
            if_a.mem_rd         = 1'b0;
            if_a.mem_wr         = 1'b0;
            if_a.address        = 17'($urandom);
            if_a.mem_write_data = 12'($urandom);
            sa_rdata = (!fb && c == last - 1) ? srd : 8'($urandom);
            fa_rdata = (fb && c == 2) ? frd : 12'($urandom);
            #1;
            e_ce   = !fb && (c <= last - 1);
            e_oe   = e_ce && rde;
            e_we   = e_ce && wr;
            e_re   = fb && (c == 1) && rde;
            e_fwe  = fb && (c == 1) && wr;
            e_rdv  = (c == last) && rde;
            e_busy = (c < last);
            if (c == last && rde)
                exp_rd = fb ? frd : {{4{srd[7]}}, srd};
            exp_v = {e_ce, e_oe, e_we, e_re, e_fwe, e_rdv, e_busy};
            got_v = {sa_ce, sa_oe, sa_we, fa_re, fa_we,
                     if_a.rd_valid, if_a.mem_busy};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL strobes fb=%0b c=%0d got=%b exp=%b",
                         fb, c, got_v, exp_v);
            end
            checks++;
            if (if_a.mem_read_data !== exp_rd) begin
                failures++;
                $display("FAIL read_data c=%0d got=%h exp=%h",
                         c, if_a.mem_read_data, exp_rd);
            end
            if (e_ce) begin
                checks++;
                if (sa_addr !== a || (wr && sa_wdata !== wd[7:0])) begin
                    failures++;
                    $display("FAIL sram_bus c=%0d addr=%h/%h wdata=%h/%h",
                             c, sa_addr, a, sa_wdata, wd[7:0]);
                end
            end
            if (fb && c == 1) begin
                checks++;
                if (fa_addr !== a || (wr && fa_wdata !== wd)) begin
                    failures++;
                    $display("FAIL fb_bus addr=%h/%h wdata=%h/%h",
                             fa_addr, a, fa_wdata, wd);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        if_a.mem_rd = 1'b1;
        if_a.mem_wr = 1'b0;
        if_a.address = 17'h00010;
        if_a.mem_write_data = 12'h000;
        if_b.mem_rd = 1'b0;
        if_b.mem_wr = 1'b0;
        if_b.address = 17'h0;
        if_b.mem_write_data = 12'h0;
        sa_rdata = 8'h0;
        sb_rdata = 8'h0;
        fa_rdata = 12'h0;
        fb_rdata_b = 12'h0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (if_a.mem_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", if_a.mem_busy);
        end
        checks++;
        if ({sa_ce, sa_oe, sa_we, fa_re, fa_we, if_a.rd_valid} !== 6'b0 ||
            if_a.mem_read_data !== 12'h0 || sa_addr !== 16'h0 ||
            fa_addr !== 16'h0 || sa_wdata !== 8'h0 || fa_wdata !== 12'h0) begin
            failures++;
            $display("FAIL reset_outputs strobes=%b rd=%h addr=%h exp=0",
                     {sa_ce, sa_oe, sa_we, fa_re, fa_we, if_a.rd_valid},
                     if_a.mem_read_data, sa_addr);
        end
        if_a.mem_rd = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        exp_rd = 12'h0;
    endtask

    task automatic test_sram_signed_read();
        run_access(1'b0, 16'h0123, 1'b1, 1'b0, 12'h000, 8'h9C, 12'h000);
        checks++;
        if (if_a.mem_read_data !== 12'hF9C) begin
            failures++;
            $display("FAIL signed_read got=%h exp=F9C", if_a.mem_read_data);
        end
    endtask

    task automatic test_sram_write_read();
        run_access(1'b0, 16'h00FF, 1'b0, 1'b1, 12'hA5B, 8'h00, 12'h000);
        run_access(1'b0, 16'h00FF, 1'b1, 1'b0, 12'h000, 8'h5B, 12'h000);
        checks++;
        if (if_a.mem_read_data !== 12'h05B) begin
            failures++;
            $display("FAIL pos_read got=%h exp=05B", if_a.mem_read_data);
        end
    endtask

    task automatic test_fb_read();
        run_access(1'b1, 16'h2000, 1'b1, 1'b0, 12'h000, 8'h00, 12'hABC);
        checks++;
        if (if_a.mem_read_data !== 12'hABC) begin
            failures++;
            $display("FAIL fb_read got=%h exp=ABC", if_a.mem_read_data);
        end
    endtask

    task automatic test_simultaneous();
        run_access(1'b1, 16'h0042, 1'b1, 1'b1, 12'h123, 8'h00, 12'hFFF);
    endtask

    task automatic test_random();
        bit rd, wr;
        for (int i = 0; i < 24; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            run_access(1'($urandom), 16'($urandom), rd, wr,
                       12'($urandom), 8'($urandom), 12'($urandom));
        end
    endtask

    task automatic test_reset_mid_access();
        run_access(1'b0, 16'h0777, 1'b1, 1'b0, 12'h000, 8'h3C, 12'h000);
        if_a.address = 17'h00555;
        if_a.mem_rd  = 1'b1;
        sa_rdata     = 8'h7E;
        @(posedge clock);
        #1;
        if_a.mem_rd = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (if_a.mem_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_busy got=%b exp=0", if_a.mem_busy);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({sa_ce, sa_oe, sa_we, if_a.rd_valid} !== 4'b0 ||
            if_a.mem_read_data !== 12'h0) begin
            failures++;
            $display("FAIL midreset_out strobes=%b rd=%h exp=0",
                     {sa_ce, sa_oe, sa_we, if_a.rd_valid},
                     if_a.mem_read_data);
        end
        reset  = 1'b0;
        exp_rd = 12'h0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if (if_a.rd_valid !== 1'b0 || sa_ce !== 1'b0 ||
                if_a.mem_read_data !== exp_rd) begin
                failures++;
                $display("FAIL midreset_after c=%0d rdv=%b ce=%b rd=%h",
                         c, if_a.rd_valid, sa_ce, if_a.mem_read_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_b;
        exp_b = 12'h0;
        sb_rdata     = 8'h80;
        if_b.address = 17'h00321;
        if_b.mem_rd  = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (c % 3 == 2) exp_b = 12'hF80;
            checks++;
            if (if_b.rd_valid !== (c % 3 == 2) ||
                if_b.mem_busy !== (c % 3 != 2) ||
                if_b.mem_read_data !== exp_b) begin
                failures++;
                $display("FAIL b2b c=%0d rdv=%b busy=%b rd=%h exp_rd=%h",
                         c, if_b.rd_valid, if_b.mem_busy,
                         if_b.mem_read_data, exp_b);
            end
            @(posedge clock);
            #1;
        end
        if_b.mem_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sram_signed_read();
        test_sram_write_read();
        test_fb_read();
        test_simultaneous();
        test_random();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
